// File: rtl/g2_readout_seq.sv
// g2 histogram readout sequencer: accumulation window, pipeline flush, then a
// read/stream/(clear) walk over every bin. Optional bin clear: G2_CLEAR_ON_READ_EN.
module g2_readout_seq #(
  parameter int unsigned DAT_W  = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned UNIT_W = 5,
  parameter int unsigned FLUSH  = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic              cont,
  input  logic [31:0]       winLen,
  output logic              accEn,
  output logic [UNIT_W-1:0] memSel,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRe,
  input  logic [DAT_W-1:0]  memRdat,
  output logic              memWe,
  output logic [DAT_W-1:0]  g2Dat,
  output logic              g2V,
  input  logic              g2R,
  output logic              busy,
  output logic [15:0]       frameCnt
);

  localparam int unsigned IDX_W = UNIT_W + ADDR_W;
  // A zero flush length still spends one cycle in FLUSH_W to reset the index.
  localparam logic [31:0] FLUSH_LD = (FLUSH == 0) ? 32'd1 : 32'(FLUSH);

  typedef enum logic [2:0] {IDLE, ACC, FLUSH_W, RD, CAP, OUT} state_t;

  state_t             state, state_nxt;
  logic [31:0]        win_q;
  logic [31:0]        cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DAT_W-1:0]   dat_q;
  logic [15:0]        frame_q;
  logic [31:0]        win_ld;
  logic               cnt_last;
  logic               idx_last;

  assign win_ld   = (winLen == 32'd0) ? 32'd1 : winLen;
  assign cnt_last = (cnt_q == 32'd1);
  assign idx_last = &idx_q;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accEn     = 1'b0;
    memRe     = 1'b0;
    memWe     = 1'b0;
    g2V       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACC;
      end
      ACC: begin
        accEn = 1'b1;
        if (cnt_last) state_nxt = FLUSH_W;
      end
      FLUSH_W: begin
        if (cnt_last) state_nxt = RD;
      end
      RD: begin
        memRe     = 1'b1;
        state_nxt = CAP;
      end
      CAP: begin
`ifdef G2_CLEAR_ON_READ_EN
        memWe = 1'b1;
`endif
        state_nxt = OUT;
      end
      OUT: begin
        g2V = 1'b1;
        if (g2R) begin
          if (!idx_last)  state_nxt = RD;
          else if (cont)  state_nxt = ACC;
          else            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cnt_q is shared: window length in ACC, then flush length in FLUSH_W.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      win_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      dat_q   <= '0;
      frame_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            win_q <= win_ld;
            cnt_q <= win_ld;
          end
        end
        ACC: begin
          cnt_q <= cnt_last ? FLUSH_LD : cnt_q - 32'd1;
        end
        FLUSH_W: begin
          cnt_q <= cnt_q - 32'd1;
          idx_q <= '0;
        end
        CAP: begin
          dat_q <= memRdat;
        end
        OUT: begin
          if (g2R) begin
            idx_q <= idx_q + IDX_W'(1);
            if (idx_last) begin
              frame_q <= frame_q + 16'd1;
              if (cont) cnt_q <= win_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign memSel   = idx_q[IDX_W-1:ADDR_W];
  assign memAddr  = idx_q[ADDR_W-1:0];
  assign g2Dat    = dat_q;
  assign frameCnt = frame_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_g2_readout_seq.sv
// Randomized bench for g2_readout_seq (8 bins) against a bin-level reference model.
module tb_g2_readout_seq;

  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic [31:0] winLen = '0;
  logic        accEn;
  logic [0:0]  memSel;
  logic [1:0]  memAddr;
  logic        memRe;
  logic [31:0] memRdat = '0;
  logic        memWe;
  logic [31:0] g2Dat;
  logic        g2V;
  logic        g2R = 1'b1;
  logic        busy;
  logic [15:0] frameCnt;

  g2_readout_seq #(.DAT_W(32), .ADDR_W(2), .UNIT_W(1), .FLUSH(4)) dut (
    .clk(clk), .RST(RST), .start(start), .cont(cont), .winLen(winLen),
    .accEn(accEn), .memSel(memSel), .memAddr(memAddr), .memRe(memRe),
    .memRdat(memRdat), .memWe(memWe), .g2Dat(g2Dat), .g2V(g2V), .g2R(g2R),
    .busy(busy), .frameCnt(frameCnt)
  );

  initial forever #5 clk = ~clk;

  int nchecks = 0;
  int nerrs   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    if (obs !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Histogram memory environment: reset preloads bin i with 100+i.
  logic [31:0] mem [NB];
  always @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < NB; i++) mem[i] <= 32'(100 + i);
    end else begin
      if (memWe) mem[{memSel, memAddr}] <= '0;
      if (memRe) memRdat <= mem[{memSel, memAddr}];
    end
  end

  // Downstream ready: 0 = always, 1 = one cycle in three, 2 = random, 3 = stalled.
  int rmode = 0;
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: g2R = 1'b1;
        1: g2R = (ph == 0);
        2: g2R = 1'($urandom_range(0, 1));
        default: g2R = 1'b0;
      endcase
      ph = (ph + 1) % 3;
    end
  end

  // Reference model: expected bin contents, next bin to stream, completed frames.
  logic [31:0] ref_mem [NB];
  int          hs_idx;
  logic [15:0] exp_frames;
  int          exp_win = 1;

  logic        prev_acc, prev_re, prev_v, prev_r, after_last, last_cont, gap_active;
  logic [2:0]  prev_addr;
  logic [31:0] prev_dat;
  int          acc_run, gap;

  always @(negedge clk) begin
    if (RST) begin
      for (int i = 0; i < NB; i++) ref_mem[i] = 32'(100 + i);
      hs_idx = 0; exp_frames = '0;
      prev_acc = 0; prev_re = 0; prev_v = 0; prev_r = 0; after_last = 0;
      last_cont = 0; gap_active = 0; prev_addr = '0; prev_dat = '0;
      acc_run = 0; gap = 0;
    end else begin
      check("frame_cnt", frameCnt, exp_frames);
      if (after_last) begin
        check("post_frame_accEn", accEn, last_cont);
        check("post_frame_busy", busy, last_cont);
        after_last = 0;
      end
      check("v_acc_excl", g2V & accEn, 0);
      check("re_we_excl", memRe & memWe, 0);
`ifdef G2_CLEAR_ON_READ_EN
      if (memWe) begin
        check("we_after_re", prev_re, 1);
        check("we_addr", {memSel, memAddr}, prev_addr);
      end
`else
      check("we_tied", memWe, 0);
`endif
      if (prev_v && !prev_r) begin
        check("hold_v", g2V, 1);
        check("hold_dat", g2Dat, prev_dat);
      end
      if (accEn) acc_run++;
      else if (prev_acc) begin
        check("win_len", acc_run, exp_win);
        acc_run = 0; gap_active = 1; gap = 1;
      end else if (gap_active) begin
        if (memRe) begin
          check("flush_gap", gap, 4);
          gap_active = 0;
        end else gap++;
      end
      if (g2V && g2R) begin
        check("bin_dat", g2Dat, ref_mem[hs_idx]);
        check("bin_idx", {memSel, memAddr}, hs_idx);
`ifdef G2_CLEAR_ON_READ_EN
        ref_mem[hs_idx] = '0;
`endif
        if (hs_idx == NB - 1) begin
          exp_frames = exp_frames + 16'd1;
          after_last = 1;
          last_cont  = cont;
        end
        hs_idx = (hs_idx + 1) % NB;
      end
      prev_acc = accEn; prev_re = memRe; prev_v = g2V; prev_r = g2R;
      prev_addr = {memSel, memAddr}; prev_dat = g2Dat;
    end
  end

  task automatic do_start(input logic [31:0] wl, input bit accept);
    @(posedge clk); #1;
    if (accept) exp_win = (wl == 0) ? 1 : int'(wl);
    winLen = wl;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    winLen = 32'hDEAD_0007;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(tag, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_accEn"}, accEn, 0);
    check({tag, "_memRe"}, memRe, 0);
    check({tag, "_memWe"}, memWe, 0);
    check({tag, "_g2V"}, g2V, 0);
    check({tag, "_memSel"}, memSel, 0);
    check({tag, "_memAddr"}, memAddr, 0);
    check({tag, "_g2Dat"}, g2Dat, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frameCnt"}, frameCnt, 0);
  endtask

  initial begin
    logic [15:0] base, seen;
    bit          hit;

    repeat (3) @(posedge clk);
    #1 RST = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");

    // Single frame, full-rate readout.
    rmode = 0; cont = 0;
    do_start(5, 1);
    wait_idle("frame1_idle");

    // Slow consumer.
    rmode = 1;
    do_start(3, 1);
    wait_idle("slow_idle");

    // Back-to-back frames via cont.
    rmode = 0; cont = 1;
    base = exp_frames;
    do_start(2, 1);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_frames != base) break;
    end
    @(posedge clk); #1 cont = 0;
    wait_idle("cont_idle");
    check("cont_frames", exp_frames - base, 2);

    // Zero-length window, and start pulses that must be ignored.
    do_start(0, 1);
    wait_idle("win0_idle");
    do_start(6, 1);
    do_start(9, 0);
    hit = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (g2V) begin hit = 1; break; end
    end
    check("reach_out", hit, 1);
    do_start(2, 0);
    wait_idle("ignore_idle");

    // Reset while bin 3 is waiting in OUT.
    rmode = 0;
    do_start(3, 1);
    hit = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (memRe && {memSel, memAddr} == 3'd3) begin hit = 1; break; end
    end
    check("reach_bin3", hit, 1);
    rmode = 3;
    hit = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (g2V) begin hit = 1; break; end
    end
    check("bin3_out", hit, 1);
    #2 RST = 1'b1;
    #1 check_reset_outputs("midrst");
    @(posedge clk); @(posedge clk); #1 RST = 1'b0;
    rmode = 0;
    do_start(1, 1);
    wait_idle("post_rst_idle");

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      rmode = $urandom_range(0, 2);
      cont  = 1'($urandom_range(0, 1));
      base  = exp_frames;
      seen  = exp_frames;
      do_start($urandom_range(0, 10), 1);
      for (int i = 0; i < 4000; i++) begin
        @(negedge clk);
        if (!busy) break;
        if (exp_frames != seen) begin
          seen = exp_frames;
          @(posedge clk); #1;
          cont = (exp_frames - base < 16'd3) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
      check("rand_idle", busy, 0);
      cont = 0;
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
